// File: rtl/coproc_ui_pkg.sv
// Codes shared by mode_control, the display block and the scaling coprocessor.
package coproc_ui_pkg;

  typedef enum logic [1:0] {
    ALG_NN = 2'd0,
    ALG_PR = 2'd1,
    ALG_DC = 2'd2,
    ALG_BA = 2'd3
  } algo_e;

  typedef enum logic [1:0] {
    Z1X = 2'd0,
    Z2X = 2'd1,
    Z4X = 2'd2,
    Z8X = 2'd3
  } zoom_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START_REQ = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  function automatic algo_e algo_next(input algo_e a);
    return algo_e'(a + 2'd1);
  endfunction

  // Opposing zoom requests in one cycle cancel; both directions saturate.
  function automatic zoom_e zoom_step(input zoom_e z, input logic up, input logic down);
    zoom_e r;
    r = z;
    if (up && !down && z != Z8X) r = zoom_e'(z + 2'd1);
    if (down && !up && z != Z1X) r = zoom_e'(z - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stable-sample debounce, registered press pulse.
module key_debounce
  import coproc_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DEBOUNCE_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  logic                  sync1_q, sync2_q;
  logic                  level_q, level_d;
  logic                  level_prev_q;
  logic                  press_q, press_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                           cnt_d   = cnt_q + DEBOUNCE_W'(1);
    end
    // Edge detected on the registered level, so the pulse trails acceptance by one cycle.
    press_d = level_prev_q & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mode_control.sv
// Button-driven algorithm/zoom selection and START/BUSY handshake to the scaling coprocessor.
module mode_control
  import coproc_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DEBOUNCE_W      = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] KEY,
  input  logic       BUSY,
  output logic [1:0] ALGORITHM,
  output logic [1:0] ZOOM_LEVEL,
  output logic       START,
  output logic       READY,
  output logic       ERROR
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0] press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DEBOUNCE_W      (DEBOUNCE_W)
    ) u_db (
      .clk   (CLK),
      .rst   (RESET),
      .key_n (KEY[i]),
      .press (press[i])
    );
  end

  state_e        state_q, state_d;
  algo_e         algo_q, algo_d;
  zoom_e         zoom_q, zoom_d;
  logic          start_q, start_d;
  logic          error_q, error_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    state_d = state_q;
    algo_d  = algo_q;
    zoom_d  = zoom_q;
    start_d = start_q;
    error_d = error_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        zoom_d = zoom_step(zoom_q, press[0], press[1]);
        if (press[2]) algo_d = algo_next(algo_q);
        if (|press) error_d = 1'b0;
        if (press[3]) begin
          state_d = ST_START_REQ;
          start_d = 1'b1;
          tcnt_d  = '0;
        end
      end
      ST_START_REQ: begin
        if (BUSY) begin
          state_d = ST_RUN;
          start_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          start_d = 1'b0;
          error_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_RUN: begin
        if (!BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      algo_q  <= ALG_NN;
      zoom_q  <= Z1X;
      start_q <= 1'b0;
      error_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      algo_q  <= algo_d;
      zoom_q  <= zoom_d;
      start_q <= start_d;
      error_q <= error_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign ALGORITHM  = algo_q;
  assign ZOOM_LEVEL = zoom_q;
  assign START      = start_q;
  assign ERROR      = error_q;
  assign READY      = (state_q == ST_IDLE);

endmodule
